// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU arbiter front end.
// Opcode encodings, the arbiter FSM state type and the {Z,V,N} flag indices.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int FLAG_W = 3;

  // ALU opcodes; anything not listed has no defined function in the ALU
  localparam logic [OPC_W-1:0] ADD     = 4'h0;
  localparam logic [OPC_W-1:0] SUB     = 4'h1;
  localparam logic [OPC_W-1:0] AND_OP  = 4'h2;
  localparam logic [OPC_W-1:0] OR_OP   = 4'h3;
  localparam logic [OPC_W-1:0] XOR_OP  = 4'h4;
  localparam logic [OPC_W-1:0] ALU_NOP = 4'hF;

  // Bit positions inside the {Z,V,N} flags vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Select the operand pair of the granted requester
  function automatic logic [DATA_W-1:0] pick16(input logic sel,
                                               input logic [DATA_W-1:0] v0,
                                               input logic [DATA_W-1:0] v1);
    logic [DATA_W-1:0] r;
    if (sel) begin
      r = v1;
    end else begin
      r = v0;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way grant logic for the ALU arbiter.
// ALU_ARB_RR_EN defined   -> round-robin with a last_grant register (reset 1,
//                            so requester 0 wins the first contention).
// ALU_ARB_RR_EN undefined -> fixed priority, requester 0 always wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic req0_i,
  input  logic req1_i,
  input  logic advance_i,  // a grant was consumed this cycle
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

`ifdef ALU_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  // Next last_grant: remember whoever was granted on a consumed grant
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i) begin
      last_grant_d = gnt_idx_o;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // last_grant register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Round-robin grant: on contention the requester not granted last wins
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_idx_o   = 1'b0;
    if (req0_i && req1_i) begin
      gnt_idx_o = ~last_grant_q;
    end else if (req1_i) begin
      gnt_idx_o = 1'b1;
    end else begin
      gnt_idx_o = 1'b0;
    end
  end
`else
  // Clock, reset and advance are only consumed by the round-robin variant
  logic unused_fixed_prio;
  assign unused_fixed_prio = &{1'b0, clk, rst, advance_i};

  // Fixed-priority grant: requester 0 wins whenever it is requesting
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_idx_o   = 1'b0;
    if (req0_i) begin
      gnt_idx_o = 1'b0;
    end else if (req1_i) begin
      gnt_idx_o = 1'b1;
    end else begin
      gnt_idx_o = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute issue port (requester 0)
// and the debug/self-test port (requester 1). One op in flight at a time:
// IDLE (accept) -> EXEC (drive ALU one cycle) -> RESP (hold until consumed).
// Outside EXEC the ALU sees ALU_NOP with zero operands so its flag register
// is left alone and the live flags on resp_flags stay stable.
// Optional feature macro: ALU_ARB_RR_EN (round-robin arbitration).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [FLAG_W-1:0] resp_flags
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic gnt_valid_s;
  logic gnt_idx_s;
  logic accept_s;
  logic owner_resp_ready_s;

  // A request is taken whenever the FSM is idle and anyone is requesting
  assign accept_s = (state_q == IDLE) && gnt_valid_s;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req0_i      (req0_valid),
    .req1_i      (req1_valid),
    .advance_i   (accept_s),
    .gnt_valid_o (gnt_valid_s),
    .gnt_idx_o   (gnt_idx_s)
  );

  // Response-ready of whichever requester owns the in-flight op
  always_comb begin
    if (owner_q) begin
      owner_resp_ready_s = resp1_ready;
    end else begin
      owner_resp_ready_s = resp0_ready;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (owner_resp_ready_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operation/result register next values: latch on accept, capture in EXEC
  always_comb begin
    owner_d  = owner_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (accept_s) begin
      owner_d  = gnt_idx_s;
      opcode_d = gnt_idx_s ? req1_opcode : req0_opcode;
      a_d      = pick16(gnt_idx_s, req0_a, req1_a);
      b_d      = pick16(gnt_idx_s, req0_b, req1_b);
    end else if (state_q == EXEC) begin
      result_d = alu_result;
    end else begin
      result_d = result_q;
    end
  end

  // Operation/result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= 1'b0;
      opcode_q <= ALU_NOP;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      owner_q  <= owner_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // FSM outputs: handshakes, ALU drive and response bus per state
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    alu_opcode  = ALU_NOP;
    alu_in1     = 16'h0000;
    alu_in2     = 16'h0000;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp_data   = 16'h0000;
    resp_flags  = 3'b000;
    case (state_q)
      IDLE: begin
        req0_ready = gnt_valid_s & ~gnt_idx_s;
        req1_ready = gnt_valid_s &  gnt_idx_s;
      end
      EXEC: begin
        alu_opcode = opcode_q;
        alu_in1    = a_q;
        alu_in2    = b_q;
      end
      RESP: begin
        if (owner_q) begin
          resp1_valid = 1'b1;
        end else begin
          resp0_valid = 1'b1;
        end
        resp_data  = result_q;
        resp_flags = alu_flags;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural saturating ALU model.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1, alu_in2;
  logic [15:0] alu_result;
  logic [2:0]  alu_flags;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [15:0] resp_data;
  logic [2:0]  resp_flags;

  int passed = 0;
  int total  = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_flags(resp_flags)
  );

  always #5 clk = ~clk;

  // ALU model: saturating signed ADD/SUB, logic ops, flags register
  logic [16:0] alu_t;
  logic [2:0]  alu_fnext;
  logic        alu_wr;
  always_comb begin
    alu_t      = 17'h0;
    alu_result = 16'hFFFF;
    alu_fnext  = alu_flags;
    alu_wr     = 1'b0;
    case (alu_opcode)
      ADD, SUB: begin
        if (alu_opcode == SUB) alu_t = {alu_in1[15], alu_in1} - {alu_in2[15], alu_in2};
        else                   alu_t = {alu_in1[15], alu_in1} + {alu_in2[15], alu_in2};
        if (alu_t[16] != alu_t[15]) alu_result = alu_t[16] ? 16'h8000 : 16'h7FFF;
        else                        alu_result = alu_t[15:0];
        alu_fnext = {alu_result == 16'h0000, alu_t[16] != alu_t[15], alu_result[15]};
        alu_wr    = 1'b1;
      end
      AND_OP, OR_OP, XOR_OP: begin
        if (alu_opcode == AND_OP)     alu_result = alu_in1 & alu_in2;
        else if (alu_opcode == OR_OP) alu_result = alu_in1 | alu_in2;
        else                          alu_result = alu_in1 ^ alu_in2;
        alu_fnext = {alu_result == 16'h0000, 1'b0, alu_result[15]};
        alu_wr    = 1'b1;
      end
      default: begin
        alu_result = 16'hFFFF;
        alu_wr     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        alu_flags <= 3'b000;
    else if (alu_wr) alu_flags <= alu_fnext;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".r0"},   req0_ready, 1'b0);
    chk({tag, ".r1"},   req1_ready, 1'b0);
    chk({tag, ".v0"},   resp0_valid, 1'b0);
    chk({tag, ".v1"},   resp1_valid, 1'b0);
    chk({tag, ".opc"},  alu_opcode, 4'hF);
    chk({tag, ".in"},   {alu_in1, alu_in2}, 32'h0);
    chk({tag, ".data"}, resp_data, 16'h0000);
    chk({tag, ".flg"},  resp_flags, 3'b000);
  endtask

  // One complete operation with resp_ready held high
  task automatic run_op(input int r, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_d,
                        input logic [2:0] exp_f, input string tag);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    if (r == 0) begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end
    #1;
    chk({tag, ".rdy"},  (r == 0) ? req0_ready : req1_ready, 1'b1);
    chk({tag, ".xrdy"}, (r == 0) ? req1_ready : req0_ready, 1'b0);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, ".exop"}, alu_opcode, op);
    chk({tag, ".exab"}, {alu_in1, alu_in2}, {a, b});
    chk({tag, ".exv"},  {resp0_valid, resp1_valid}, 2'b00);
    tick;
    chk({tag, ".v"},    {resp0_valid, resp1_valid}, (r == 0) ? 2'b10 : 2'b01);
    chk({tag, ".data"}, resp_data, exp_d);
    chk({tag, ".flg"},  resp_flags, exp_f);
    chk({tag, ".nop"},  alu_opcode, 4'hF);
    tick;
    chk({tag, ".done"}, {resp0_valid, resp1_valid, resp_data}, 18'h0);
  endtask

  logic exp_g;

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = 4'h0; req1_opcode = 4'h0;
    req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    tick; tick;
    chk_quiet("reset");
    rst = 1'b1;
    tick;

    run_op(0, ADD, 16'h0003, 16'h0004, 16'h0007, 3'b000, "add");
    run_op(1, SUB, 16'h0005, 16'h0005, 16'h0000, 3'b100, "sub_r1");
    run_op(0, ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, "add_sat");
    run_op(0, 4'h9, 16'h1234, 16'h5678, 16'hFFFF, 3'b010, "undef");
    run_op(1, XOR_OP, 16'h00F0, 16'h000F, 16'h00FF, 3'b000, "xor");

    // Fresh arbitration history for the contention test
    rst = 1'b0; tick; rst = 1'b1; tick;
    req0_valid = 1'b1; req0_opcode = ADD; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_opcode = ADD; req1_a = 16'h0010; req1_b = 16'h0010;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (i % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      chk($sformatf("cont%0d.gnt", i), {req0_ready, req1_ready}, {~exp_g, exp_g});
      tick;
      tick;
      chk($sformatf("cont%0d.v", i), {resp0_valid, resp1_valid}, {~exp_g, exp_g});
      chk($sformatf("cont%0d.data", i), resp_data, exp_g ? 16'h0020 : 16'h0002);
      tick;
    end
    req0_valid = 1'b0;
    #1;
    chk("cont.r1only", {req0_ready, req1_ready}, 2'b01);
    tick;
    req1_valid = 1'b0;
    tick;
    chk("cont.r1resp", {resp0_valid, resp1_valid, resp_data}, {2'b01, 16'h0020});
    tick;

    // Backpressure: hold resp0_ready low while requester 1 waits
    req0_valid = 1'b1; req0_opcode = SUB; req0_a = 16'h0001; req0_b = 16'h0002;
    resp0_ready = 1'b0;
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_opcode = ADD; req1_a = 16'h0001; req1_b = 16'h0001;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.v", i), {resp0_valid, resp1_valid}, 2'b10);
      chk($sformatf("bp%0d.data", i), {resp_data, resp_flags}, {16'hFFFF, 3'b001});
      chk($sformatf("bp%0d.r1", i), req1_ready, 1'b0);
      chk($sformatf("bp%0d.opc", i), alu_opcode, 4'hF);
      tick;
    end
    resp0_ready = 1'b1;
    #1;
    chk("bp.same_cycle_rdy", req1_ready, 1'b0);
    tick;
    chk("bp.after_rdy", {resp0_valid, req1_ready}, 2'b01);
    req1_valid = 1'b0;
    tick;

    // Reset while an op is in EXEC
    req0_valid = 1'b1; req0_opcode = ADD; req0_a = 16'h0002; req0_b = 16'h0002;
    tick;
    req0_valid = 1'b0;
    chk("rstx.exec", alu_opcode, ADD);
    #2;
    rst = 1'b0;
    tick;
    chk_quiet("rstx");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rstx.noresp%0d", i), {resp0_valid, resp1_valid}, 2'b00);
    end
    run_op(0, ADD, 16'h0002, 16'h0003, 16'h0005, 3'b000, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
